coin_acceptor: RTL

Front-end stage of the coffee vending controller. Takes the two raw, asynchronous coin-chute sensor lines (5-cent and 10-cent), then synchronises, debounces and jam-checks each one. Emits exactly one single-cycle `coins` code per physical coin, which is the 2-bit code the vending FSM consumes directly. The output is registered, carries at most one coin per cycle, and serialises coins that arrive at the same time.

---
 rtl/coin_acceptor.sv | 95 +++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises, debounces and jam-checks two coin chute sensors,
// emitting one registered single-cycle coin code per coin, 10 cents first.
module coin_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sense,
  input  logic grant,
  output logic pending,
  output logic jammed
);
  localparam int CW = $clog2(JAM_CYCLES + 1);
  localparam int LW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] JMC = CW'(JAM_CYCLES);
  localparam logic [LW-1:0] LDEB = LW'(DEBOUNCE_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, QUAL = 2'd1, HELD = 2'd2, JAM = 2'd3;
  logic [1:0] sy, st;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lo;
  logic s;
  assign s = sy[1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sy <= '0;
      st <= IDLE;
      cnt <= '0;
      lo <= '0;
      pending <= 1'b0;
      jammed <= 1'b0;
    end else begin
      sy <= {sy[0], sense};
      pending <= pending & ~grant;
      case (st)
        IDLE, QUAL:
          if (!s) begin
            st <= IDLE;
            cnt <= '0;
          end else if (cnt + CW'(1) == DEB) begin
            st <= HELD;
            cnt <= '0;
            lo <= '0;
            pending <= 1'b1;
          end else begin
            st <= QUAL;
            cnt <= cnt + CW'(1);
          end
        HELD:
          if (s) begin
            lo <= '0;
            if (cnt + CW'(1) == JMC) begin
              st <= JAM;
              cnt <= '0;
              jammed <= 1'b1;
            end else cnt <= cnt + CW'(1);
          end else if (lo + LW'(1) == LDEB) begin
            st <= IDLE;
            cnt <= '0;
            lo <= '0;
          end else lo <= lo + LW'(1);
        default:
          if (s) lo <= '0;
          else if (lo + LW'(1) == LDEB) begin
            st <= IDLE;
            lo <= '0;
            jammed <= 1'b0;
          end else lo <= lo + LW'(1);
      endcase
    end
endmodule

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sense_5,
  input  logic       sense_10,
  output logic [1:0] coins,
  output logic [1:0] jam
);
  logic p5, p10;
  coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_5 (
    .clk(clk), .reset_n(reset_n), .sense(sense_5), .grant(p5 & ~p10), .pending(p5), .jammed(jam[1])
  );
  coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_10 (
    .clk(clk), .reset_n(reset_n), .sense(sense_10), .grant(p10), .pending(p10), .jammed(jam[0])
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) coins <= 2'b00;
    else coins <= {p5 & ~p10, p10};
endmodule
